// File: rtl/morse_pkg.sv
// Shared constants for the morse input path: symbol codes, word geometry
// and the encoder FSM state encoding.
package morse_pkg;

    localparam logic [1:0] SYM_EMPTY = 2'b00;
    localparam logic [1:0] SYM_DOT   = 2'b01;
    localparam logic [1:0] SYM_DASH  = 2'b11;

    localparam int MAX_SYMBOLS = 5;
    localparam int CODE_W      = 10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PRESS  = 2'd1,
        S_GAP    = 2'd2,
        S_COMMIT = 2'd3
    } state_e;

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchronizer plus stability counter for an active-low push key.
// level is the debounced pressed level (1 = pressed).
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_n,
    output logic level
);

    localparam int W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [W-1:0] CNT_LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         sync1_q, sync2_q;
    logic         level_q;
    logic [W-1:0] cnt_q;

    // sync2_q is still active-low, so equality with level_q means they differ.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_n;
            sync2_q <= sync1_q;
            if (sync2_q == level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= ~level_q;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign level = level_q;

endmodule

// File: rtl/morse_encoder.sv
// Times debounced key presses into dot/dash symbols and packs up to five into
// a 10-bit code word. Define MORSE_ENCODER_ECHO_EN to add the echo[1:0] port.
module morse_encoder
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DASH_CYCLES     = 15000000,
    parameter int GAP_CYCLES      = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              key_in,
    input  logic              commit,
    output logic [1:0]        sym,
    output logic              sym_valid,
    output logic [2:0]        sym_count,
    output logic [CODE_W-1:0] code_out,
    output logic              code_valid,
    output logic              overflow,
    output logic              busy
`ifdef MORSE_ENCODER_ECHO_EN
    ,
    output logic [1:0]        echo
`endif
);

    localparam logic [CNT_W-1:0] DASH_C   = CNT_W'(DASH_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [2:0]       MAX_CNT  = 3'(MAX_SYMBOLS);

    logic pressed;

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
        .clock  (clock),
        .resetn (resetn),
        .raw_n  (key_in),
        .level  (pressed)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CODE_W-1:0] word_q, word_d;
    logic [2:0]        count_q, count_d;
    logic [1:0]        sym_q, sym_d;
    logic              sym_valid_q, sym_valid_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic              code_valid_q, code_valid_d;
    logic              ovf_q, ovf_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            word_q       <= '0;
            count_q      <= '0;
            sym_q        <= '0;
            sym_valid_q  <= 1'b0;
            code_q       <= '0;
            code_valid_q <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            count_q      <= count_d;
            sym_q        <= sym_d;
            sym_valid_q  <= sym_valid_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        word_d       = word_q;
        count_d      = count_q;
        sym_d        = sym_q;
        sym_valid_d  = 1'b0;
        code_d       = code_q;
        code_valid_d = 1'b0;
        ovf_d        = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (pressed) begin
                    state_d = S_PRESS;
                    cnt_d   = '0;
                end
            end
            S_PRESS: begin
                if (!pressed) begin
                    sym_d = (cnt_q == DASH_C) ? SYM_DASH : SYM_DOT;
                    for (int k = 0; k < MAX_SYMBOLS; k++) begin
                        if (count_q == 3'(k)) word_d[2*k +: 2] = sym_d;
                    end
                    count_d     = count_q + 3'd1;
                    sym_valid_d = 1'b1;
                    state_d     = S_GAP;
                    cnt_d       = '0;
                end else if (cnt_q != DASH_C) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_GAP: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Commit (explicit or timeout) outranks a press in the same cycle.
                if (commit || cnt_q == GAP_LAST) begin
                    state_d = S_COMMIT;
                end else if (pressed) begin
                    if (count_q < MAX_CNT) begin
                        state_d = S_PRESS;
                        cnt_d   = '0;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                code_d       = word_q;
                code_valid_d = 1'b1;
                word_d       = {MAX_SYMBOLS{SYM_EMPTY}};
                count_d      = '0;
                ovf_d        = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign sym        = sym_q;
    assign sym_valid  = sym_valid_q;
    assign sym_count  = count_q;
    assign code_out   = code_q;
    assign code_valid = code_valid_q;
    assign overflow   = ovf_q;
    assign busy       = (state_q != S_IDLE);

`ifdef MORSE_ENCODER_ECHO_EN
    assign echo = {(state_q == S_PRESS) && (cnt_q == DASH_C), pressed};
`endif

endmodule
